// File: rtl/push_ctrl_pkg.sv
// Shared constants for the pushbutton sequencer: state encoding, parameter
// defaults and counter width.
package push_ctrl_pkg;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned DEB_CYCLES_DEF    = 4;
  localparam int unsigned REPEAT_DELAY_DEF  = 8;
  localparam int unsigned REPEAT_PERIOD_DEF = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DEB_PRESS = 3'd1;
  localparam logic [2:0] ST_FIRE      = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_DEB_REL   = 3'd4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/push_sync.sv
// Two-flop synchronizer for the raw pushbutton level, cleared by reset.
module push_sync (
  input  logic CLK,
  input  logic RST,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/push_seq_ctrl.sv
// Debounced pushbutton sequencer: one SIG pulse per accepted press.
// Define PUSH_AUTO_REPEAT_EN to add auto-repeat pulses while the button is held.
module push_seq_ctrl
  import push_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PUSH,
  output logic       SIG,
  output logic       HELD,
  output logic [7:0] COUNT
);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
    $error("DEB_CYCLES out of range 2..65535");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 65535) begin : g_bad_delay
    $error("REPEAT_DELAY out of range 1..65535");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_bad_period
    $error("REPEAT_PERIOD out of range 1..65535");
  end

  localparam cnt_t DEB_LIM = cnt_t'(DEB_CYCLES);
  localparam cnt_t ONE     = cnt_t'(1);

  logic       push_s;
  logic [2:0] state_q, state_d;
  cnt_t       deb_cnt_q, deb_cnt_d;
  logic [7:0] count_q, count_d;

  push_sync u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .async_i(PUSH),
    .sync_o (push_s)
  );

`ifdef PUSH_AUTO_REPEAT_EN
  localparam cnt_t             DELAY_LIM  = cnt_t'(REPEAT_DELAY);
  localparam cnt_t             PERIOD_LIM = cnt_t'(REPEAT_PERIOD);
  localparam logic [CNT_W:0]   TWO        = (CNT_W+1)'(2);

  cnt_t           rep_cnt_q, rep_cnt_d;
  logic           rep_late_q, rep_late_d;
  cnt_t           rep_thresh;
  logic           rep_due;

  // FIRE itself is one cycle of the repeat interval, so HOLD lasts thresh-1.
  assign rep_thresh = rep_late_q ? PERIOD_LIM : DELAY_LIM;
  assign rep_due    = ({1'b0, rep_cnt_q} + TWO) >= {1'b0, rep_thresh};
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    count_d   = (state_q == ST_FIRE) ? count_q + 8'd1 : count_q;
`ifdef PUSH_AUTO_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rep_late_d = rep_late_q;
`endif
    case (state_q)
      ST_IDLE: begin
        deb_cnt_d = '0;
        if (push_s) begin
          state_d   = ST_DEB_PRESS;
          deb_cnt_d = ONE;
        end
      end
      ST_DEB_PRESS: begin
        if (!push_s) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LIM) begin
          state_d   = ST_FIRE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + ONE;
        end
      end
      ST_FIRE: begin
        state_d = ST_HOLD;
`ifdef PUSH_AUTO_REPEAT_EN
        rep_cnt_d = '0;
`endif
      end
      ST_HOLD: begin
        if (!push_s) begin
          state_d   = ST_DEB_REL;
          deb_cnt_d = ONE;
        end
`ifdef PUSH_AUTO_REPEAT_EN
        else if (rep_due) begin
          state_d    = ST_FIRE;
          rep_late_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + ONE;
        end
`endif
      end
      ST_DEB_REL: begin
        if (push_s) begin
          state_d   = ST_HOLD;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LIM) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
`ifdef PUSH_AUTO_REPEAT_EN
          rep_late_d = 1'b0;
`endif
        end else begin
          deb_cnt_d = deb_cnt_q + ONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      deb_cnt_q <= '0;
      count_q   <= '0;
`ifdef PUSH_AUTO_REPEAT_EN
      rep_cnt_q  <= '0;
      rep_late_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      count_q   <= count_d;
`ifdef PUSH_AUTO_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
      rep_late_q <= rep_late_d;
`endif
    end
  end

  assign SIG   = (state_q == ST_FIRE);
  assign HELD  = (state_q == ST_FIRE) || (state_q == ST_HOLD) || (state_q == ST_DEB_REL);
  assign COUNT = count_q;

endmodule
